// File: rtl/l2_ram_bank_initiator.sv
// Front end for one private L2 SRAM bank: credit-gated request port, in-order
// response FIFO, and a zero-fill engine that clears the bank after reset or on command.
module l2_ram_bank_initiator #(
  parameter int unsigned  NumWords    = 16384,
  parameter int unsigned  DataWidth   = 32,
  parameter int unsigned  RespDepth   = 3,
  parameter bit           InitOnReset = 1'b1,
  localparam int unsigned AddrWidth   = $clog2(NumWords),
  localparam int unsigned BeWidth     = (DataWidth + 7) / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DataWidth-1:0] resp_rdata_o,
  input  logic                 init_start_i,
  output logic                 init_busy_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [BeWidth-1:0]   mem_be_o,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  localparam int unsigned PtrWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned CntWidth = $clog2(RespDepth + 1);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);
  localparam logic [PtrWidth-1:0]  LastPtr  = PtrWidth'(RespDepth - 1);
  localparam logic [CntWidth-1:0]  FullCnt  = CntWidth'(RespDepth);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    DRAIN = 2'd1,
    INIT  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic                 inflight_q, inflight_d;
  logic                 inflight_we_q, inflight_we_d;
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]  count_q, count_d;
  logic [DataWidth-1:0] fifo_q [RespDepth];
  logic [DataWidth-1:0] fifo_d [RespDepth];

  logic credit_ok;
  logic fifo_empty;
  logic push;
  logic pop;

  // Credit counts both queued and in-flight responses so a push never meets a full FIFO;
  // it deliberately ignores this cycle's pop to keep resp_ready_i off the gnt_o path.
  assign credit_ok  = (32'(count_q) + 32'(inflight_q)) < RespDepth;
  assign fifo_empty = (count_q == '0);
  assign push       = inflight_q;
  assign pop        = !fifo_empty && resp_ready_i;

  assign resp_valid_o = !fifo_empty;
  assign resp_rdata_o = fifo_empty ? '0 : fifo_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fifo_d   = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = inflight_we_q ? '0 : mem_rdata_i;
      wr_ptr_d         = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    inflight_d    = 1'b0;
    inflight_we_d = inflight_we_q;
    gnt_o         = 1'b0;
    init_busy_o   = 1'b1;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = addr_i;
    mem_wdata_o   = wdata_i;
    mem_be_o      = be_i;
    unique case (state_q)
      SERVE: begin
        init_busy_o   = 1'b0;
        gnt_o         = req_i && credit_ok;
        mem_req_o     = gnt_o;
        mem_we_o      = gnt_o && we_i;
        inflight_d    = gnt_o;
        inflight_we_d = we_i;
        if (init_start_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!inflight_q && fifo_empty) state_d = INIT;
      end
      INIT: begin
        // Held off while reset is asserted so the SRAM sees no request during reset.
        mem_req_o   = rst_ni;
        mem_we_o    = rst_ni;
        mem_addr_o  = cnt_q;
        mem_wdata_o = '0;
        mem_be_o    = '1;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          cnt_d   = '0;
          state_d = SERVE;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= InitOnReset ? INIT : SERVE;
      cnt_q         <= '0;
      inflight_q    <= 1'b0;
      inflight_we_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      inflight_q    <= inflight_d;
      inflight_we_q <= inflight_we_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Response storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && (count_q == FullCnt)));

endmodule

// File: tb/tb_l2_ram_bank_initiator.sv
// Bench for l2_ram_bank_initiator: SRAM model, reference memory and in-order
// response expectation queue, with one task per scenario.
module tb_l2_ram_bank_initiator;
  localparam int NW = 16;
  localparam int DW = 32;
  localparam int RD = 3;
  localparam int AW = $clog2(NW);
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic          resp_ready = 1'b0;
  logic          init_start = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [BW-1:0] be = '0;

  logic          gnt_o, resp_valid_o, init_busy_o, mem_req_o, mem_we_o;
  logic [DW-1:0] resp_rdata_o, mem_wdata_o, sram_rdata;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_be_o;

  logic [DW-1:0] sram    [NW];
  logic [DW-1:0] ref_mem [NW];
  logic [DW-1:0] exp_q[$];
  int            expc_q[$];
  logic [DW-1:0] obs_q[$];
  int            obsc_q[$];
  int            gntc_q[$];
  bit            model_clear = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  l2_ram_bank_initiator #(
    .NumWords(NW), .DataWidth(DW), .RespDepth(RD), .InitOnReset(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_o), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata_o),
    .init_start_i(init_start), .init_busy_o(init_busy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] m);
    merge = old;
    for (int b = 0; b < BW; b++) if (m[b]) merge[8*b +: 8] = nw[8*b +: 8];
  endfunction

  // Single-port SRAM with one-cycle read latency; contents scrambled while in reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) sram[i] <= $urandom;
      sram_rdata <= '0;
    end else if (mem_req_o) begin
      if (mem_we_o) sram[mem_addr_o] <= merge(sram[mem_addr_o], mem_wdata_o, mem_be_o);
      else sram_rdata <= sram[mem_addr_o];
    end
  end

  // Reference: each grant applies to the ideal memory in order; its response is due 2 cycles later.
  always @(negedge clk) begin
    if (model_clear) for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    if (rst_n) begin
      if (gnt_o) begin
        gntc_q.push_back(cyc);
        expc_q.push_back(cyc + 2);
        if (we) begin
          exp_q.push_back('0);
          ref_mem[addr] = merge(ref_mem[addr], wdata, be);
        end else begin
          exp_q.push_back(ref_mem[addr]);
        end
      end
      if (resp_valid_o && resp_ready) begin
        obs_q.push_back(resp_rdata_o);
        obsc_q.push_back(cyc);
      end
    end
  end

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] m, output bit ok);
    req = 1'b1; we = w; addr = a; wdata = d; be = m; ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (gnt_o) ok = 1'b1;
      @(posedge clk); #1;
    end
    req = 1'b0;
  endtask

  task automatic wait_drain(input int eb, input int ob, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #1;
      if ((exp_q.size() - eb) == (obs_q.size() - ob) && !resp_valid_o) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; model_clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b want 0", gnt_o); end
    checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", resp_valid_o); end
    checks++; if (resp_rdata_o !== '0) begin errors++; $display("FAIL rst_rdata: got %h want 0", resp_rdata_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req_o); end
    checks++; if (init_busy_o !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", init_busy_o); end
    @(posedge clk); #1;
    model_clear = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_init_clear(input string tag);
    int n;
    int nonzero;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!init_busy_o) break;
      checks++;
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== AW'(n) ||
          mem_wdata_o !== '0 || mem_be_o !== 4'hF || gnt_o !== 1'b0) begin
        errors++;
        $display("FAIL %s_write%0d: req=%b we=%b addr=%0d wdata=%h be=%h gnt=%b want 1 1 %0d 0 f 0",
                 tag, n, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, gnt_o, n);
      end
      n++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checks++; if (n != NW) begin errors++; $display("FAIL %s_busy_cycles: got %0d want %0d", tag, n, NW); end
    nonzero = 0;
    for (int i = 0; i < NW; i++) if (sram[i] !== '0) nonzero++;
    checks++; if (nonzero != 0) begin errors++; $display("FAIL %s_zeroed: %0d nonzero words want 0", tag, nonzero); end
  endtask

  task automatic test_write_read;
    int eb, ob;
    bit ok1, ok2, okd;
    eb = exp_q.size(); ob = obs_q.size();
    resp_ready = 1'b1;
    issue(1'b1, 4'd5, 32'hDEADBEEF, 4'hF, ok1);
    issue(1'b0, 4'd5, 32'h0, 4'hF, ok2);
    wait_drain(eb, ob, okd);
    checks++; if (!(ok1 && ok2 && okd)) begin errors++; $display("FAIL wr_rd_timeout: gnt=%b%b drain=%b want 111", ok1, ok2, okd); end
    checks++; if (obs_q.size() - ob != 2) begin errors++; $display("FAIL wr_rd_count: got %0d want 2", obs_q.size() - ob); end
    else begin
      checks++; if (obs_q[ob] !== 32'h0) begin errors++; $display("FAIL wr_rd_wresp: got %h want 0", obs_q[ob]); end
      checks++; if (obs_q[ob+1] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_rdata: got %h want deadbeef", obs_q[ob+1]); end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsc_q[ob+k] != expc_q[eb+k]) begin
          errors++; $display("FAIL wr_rd_latency%0d: resp cycle %0d want %0d", k, obsc_q[ob+k], expc_q[eb+k]);
        end
      end
    end
  endtask

  task automatic test_byte_enable;
    int eb, ob, n;
    bit ok, okd;
    logic [AW-1:0] a;
    eb = exp_q.size(); ob = obs_q.size();
    resp_ready = 1'b1;
    n = 0;
    issue(1'b1, 4'd9, 32'h0000AB00, 4'h2, ok); n += int'(ok);
    issue(1'b0, 4'd9, 32'h0, 4'h0, ok); n += int'(ok);
    for (int i = 0; i < 6; i++) begin
      a = AW'($urandom_range(NW - 1, 0));
      issue(1'b1, a, $urandom, BW'($urandom), ok); n += int'(ok);
      issue(1'b0, a, $urandom, BW'($urandom), ok); n += int'(ok);
    end
    wait_drain(eb, ob, okd);
    checks++; if (n != 14 || !okd || obs_q.size() - ob != 14) begin
      errors++; $display("FAIL be_count: grants %0d resps %0d drain %b want 14 14 1", n, obs_q.size() - ob, okd);
    end else begin
      checks++; if (obs_q[ob+1] !== 32'h0000AB00) begin errors++; $display("FAIL be_partial: got %h want 0000ab00", obs_q[ob+1]); end
      for (int k = 0; k < 14; k++) begin
        checks++;
        if (obs_q[ob+k] !== exp_q[eb+k] || obsc_q[ob+k] != expc_q[eb+k]) begin
          errors++; $display("FAIL be_resp%0d: got %h @%0d want %h @%0d", k, obs_q[ob+k], obsc_q[ob+k], exp_q[eb+k], expc_q[eb+k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int eb, ob, gb, n;
    bit ok, okd;
    eb = exp_q.size(); ob = obs_q.size(); gb = gntc_q.size();
    resp_ready = 1'b1;
    n = 0;
    for (int a = 0; a < 8; a++) begin issue(1'b1, AW'(a), $urandom, 4'hF, ok); n += int'(ok); end
    for (int a = 0; a < 8; a++) begin issue(1'b0, AW'(a), '0, 4'hF, ok); n += int'(ok); end
    wait_drain(eb, ob, okd);
    checks++; if (n != 16 || !okd || obs_q.size() - ob != 16) begin
      errors++; $display("FAIL b2b_count: grants %0d resps %0d drain %b want 16 16 1", n, obs_q.size() - ob, okd);
    end else begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (gntc_q[gb+k] != gntc_q[gb] + k || obsc_q[ob+k] != gntc_q[gb] + k + 2 || obs_q[ob+k] !== exp_q[eb+k]) begin
          errors++; $display("FAIL b2b_resp%0d: gnt@%0d resp %h @%0d want gnt@%0d %h @%0d", k, gntc_q[gb+k],
                             obs_q[ob+k], obsc_q[ob+k], gntc_q[gb] + k, exp_q[eb+k], gntc_q[gb] + k + 2);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int eb, ob, k, bad;
    bit held_set, okd;
    logic [DW-1:0] held;
    logic [AW-1:0] rd [6];
    eb = exp_q.size(); ob = obs_q.size();
    for (int i = 0; i < 6; i++) rd[i] = AW'($urandom_range(NW - 1, 0));
    resp_ready = 1'b0;
    k = 0; bad = 0; held_set = 1'b0; held = '0;
    req = 1'b1; we = 1'b0; be = 4'hF; addr = rd[0];
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (gnt_o) k++;
      if (resp_valid_o) begin
        if (!held_set) begin held = resp_rdata_o; held_set = 1'b1; end
        else if (resp_rdata_o !== held) bad++;
      end
      @(posedge clk); #1;
      addr = rd[k];
    end
    checks++; if (k != 3) begin errors++; $display("FAIL bp_grants: got %0d want 3", k); end
    checks++; if (!held_set || bad != 0) begin errors++; $display("FAIL bp_stable: valid=%b changes=%0d want 1 0", held_set, bad); end
    @(negedge clk);
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL bp_gnt_low: got %b want 0", gnt_o); end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    for (int c = 0; c < 40 && k < 6; c++) begin
      @(negedge clk);
      if (gnt_o) k++;
      @(posedge clk); #1;
      if (k < 6) addr = rd[k]; else req = 1'b0;
    end
    req = 1'b0;
    wait_drain(eb, ob, okd);
    checks++; if (k != 6 || !okd || obs_q.size() - ob != 6) begin
      errors++; $display("FAIL bp_count: grants %0d resps %0d drain %b want 6 6 1", k, obs_q.size() - ob, okd);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obs_q[ob+i] !== exp_q[eb+i]) begin
          errors++; $display("FAIL bp_resp%0d: got %h want %h", i, obs_q[ob+i], exp_q[eb+i]);
        end
      end
    end
  endtask

  task automatic test_init_cmd;
    int eb, ob, bad, n;
    bit ok, okd;
    resp_ready = 1'b1;
    issue(1'b1, 4'd5, 32'hDEADBEEF, 4'hF, ok);
    eb = exp_q.size() - 1; ob = obs_q.size();
    wait_drain(eb, ob, okd);
    eb = exp_q.size(); ob = obs_q.size();
    resp_ready = 1'b0;
    issue(1'b0, 4'd5, '0, 4'hF, ok);
    issue(1'b0, 4'd2, '0, 4'hF, ok);
    repeat (2) @(posedge clk);
    #1;
    init_start = 1'b1;
    @(posedge clk); #1;
    init_start = 1'b0; model_clear = 1'b1;
    req = 1'b1; we = 1'b0; addr = 4'd7;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (gnt_o !== 1'b0 || init_busy_o !== 1'b1 || resp_valid_o !== 1'b1 || mem_req_o !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    req = 1'b0; model_clear = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL ic_drain_hold: %0d bad cycles want 0", bad); end
    resp_ready = 1'b1;
    n = 0; bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!init_busy_o) break;
      if (mem_req_o && mem_we_o) begin
        if (mem_addr_o !== AW'(n) || mem_wdata_o !== '0) bad++;
        n++;
      end else if (mem_req_o || gnt_o) bad++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checks++; if (n != NW || bad != 0) begin errors++; $display("FAIL ic_clear: writes %0d bad %0d want %0d 0", n, bad, NW); end
    checks++; if (obs_q.size() - ob != 2) begin errors++; $display("FAIL ic_pending: got %0d want 2", obs_q.size() - ob); end
    else begin
      checks++; if (obs_q[ob] !== 32'hDEADBEEF || obs_q[ob+1] !== exp_q[eb+1]) begin
        errors++; $display("FAIL ic_pending_data: got %h %h want deadbeef %h", obs_q[ob], obs_q[ob+1], exp_q[eb+1]);
      end
    end
    eb = exp_q.size(); ob = obs_q.size();
    issue(1'b0, 4'd5, '0, 4'hF, ok);
    wait_drain(eb, ob, okd);
    checks++; if (!ok || obs_q.size() - ob != 1 || obs_q[ob] !== 32'h0) begin
      errors++; $display("FAIL ic_readback: resps %0d data %h want 1 00000000", obs_q.size() - ob,
                         (obs_q.size() > ob) ? obs_q[ob] : 32'hx);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    resp_ready = 1'b0;
    issue(1'b0, 4'd3, '0, 4'hF, ok);
    issue(1'b0, 4'd4, '0, 4'hF, ok);
    rst_n = 1'b0; model_clear = 1'b1;
    #1;
    checks++; if (resp_valid_o !== 1'b0 || init_busy_o !== 1'b1 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL mid_rst: valid=%b busy=%b mem_req=%b want 0 1 0", resp_valid_o, init_busy_o, mem_req_o);
    end
    repeat (2) @(posedge clk);
    #1;
    model_clear = 1'b0; rst_n = 1'b1;
    test_init_clear("mid");
  endtask

  initial begin
    test_reset();
    test_init_clear("por");
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_backpressure();
    test_init_cmd();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l2_ram_bank_initiator.md
Name: l2_ram_bank_initiator

Overview:
- Initiator-side front end for one private L2 SRAM bank.
- Accepts requests from the interconnect on a req/gnt port and drives the bank's single-port SRAM interface (req/we/addr/wdata/be, rdata one cycle after req).
- Returns in-order responses through a valid/ready channel, buffered in a small response FIFO.
- Contains a zero-initialisation engine that clears the whole bank after reset or on command.

Parameters:
- NumWords, 16384, words in the bank; AddrWidth = $clog2(NumWords) (derived, not overridable).
- DataWidth, 32, word width in bits; BeWidth = (DataWidth+7)/8 (derived).
- RespDepth, 3, response FIFO entries (>=2). Sustained one access per cycle requires RespDepth >= 3.
- InitOnReset, 1, 1 = clear the bank automatically after reset deassertion.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  interconnect request
- gnt_o  out  1  request accepted this cycle
- we_i  in  1  1 = write, 0 = read
- addr_i  in  AddrWidth  word address
- wdata_i  in  DataWidth  write data
- be_i  in  BeWidth  byte enables
- resp_valid_o  out  1  response available
- resp_ready_i  in  1  consumer accepts response
- resp_rdata_o  out  DataWidth  read data; 0 for write responses
- init_start_i  in  1  pulse: request bank clear
- init_busy_o  out  1  drain or clear in progress
- mem_req_o  out  1  SRAM request
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  AddrWidth  SRAM address
- mem_wdata_o  out  DataWidth  SRAM write data
- mem_be_o  out  BeWidth  SRAM byte enables
- mem_rdata_i  in  DataWidth  SRAM read data, valid the cycle after a read req

Behaviour:
- Clock and reset: single clock clk_i; rst_ni is asynchronous, active-low.
- Reset values:
  - FIFO empty, inflight=0, init counter=0.
  - gnt_o=0, resp_valid_o=0, resp_rdata_o=0, mem_req_o=0.
  - State = INIT if InitOnReset, else SERVE.
  - init_busy_o = InitOnReset.
- FSM states: SERVE, DRAIN, INIT.
- SERVE:
  - gnt_o = req_i && (fifo_count + inflight < RespDepth). gnt_o has no combinational path from resp_ready_i.
  - On gnt, mem_* are driven combinationally from the request: mem_req_o=1, pass-through we/addr/wdata/be.
  - inflight register is set to gnt_o.
  - In the cycle after a granted access, one entry is pushed into the FIFO: mem_rdata_i for a read, 0 for a write.
- Latency and ordering:
  - Response is visible on resp_valid_o two cycles after gnt.
  - Responses are strictly in order, exactly one per granted request.
- FIFO:
  - Head entry is presented on resp_valid_o/resp_rdata_o and popped when resp_valid_o && resp_ready_i.
  - Push and pop in the same cycle are allowed and leave the count unchanged.
  - The credit check guarantees a push never meets a full FIFO. Overflow is an assertion failure.
  - resp_rdata_o holds its value while resp_valid_o=1 and resp_ready_i=0.
- init_start_i in SERVE: go to DRAIN. A request granted in that same cycle is still completed.
- DRAIN:
  - gnt_o=0, init_busy_o=1.
  - The FIFO keeps delivering responses.
  - Go to INIT when inflight=0 and FIFO empty.
- INIT:
  - gnt_o=0, init_busy_o=1.
  - Each cycle: mem_req_o=1, mem_we_o=1, mem_addr_o=counter, mem_wdata_o=0, mem_be_o=all ones. No responses are generated.
  - Counter increments by 1; after writing NumWords-1, reset the counter to 0 and go to SERVE. init_busy_o=0 from that cycle.
  - A full clear takes exactly NumWords cycles.
- init_start_i outside SERVE: ignored.
- req_i held while gnt_o=0: no effect. The requester must keep addr/we/wdata/be stable until gnt.
- Reset asserted mid-operation: FIFO contents and in-flight responses are discarded; clear restarts from address 0 if InitOnReset.

Test Plan:
- InitOnReset=1, NumWords=16: release reset -> init_busy_o=1 for exactly 16 cycles, mem writes to addresses 0..15 with wdata 0 and be 0xF, gnt_o=0 throughout; then init_busy_o=0.
- Write addr 5 data 0xDEADBEEF be 0xF, then read addr 5, resp_ready_i=1 -> two responses: rdata 0 then 0xDEADBEEF, each 2 cycles after its gnt.
- Back-to-back reads of addrs 0..7 with resp_ready_i=1 and RespDepth=3 -> gnt every cycle, 8 in-order responses on consecutive cycles.
- resp_ready_i=0 while reads stream -> exactly 3 gnts, then gnt_o=0; resp_rdata_o stable. Raise ready -> 3 responses drain, grants resume, no loss or duplication.
- Write byte enable 0x2 data 0x0000AB00 to a zeroed word, read back -> 0x0000AB00.
- init_start_i while 2 responses are pending and ready=0 -> DRAIN with gnt_o=0; after ready=1 drains both, NumWords clear writes follow; a read of the earlier 0xDEADBEEF location then returns 0.
